measurement_window_scheduler: RTL and testbench
===============================================

Name: measurement_window_scheduler

Overview:
Sequences repeated measurement windows of frequency_analyzer_manager from a single clock domain. Drives the manager's clear/start/stop pins, waits for its irq (register dump complete), then releases stop and repeats. Runs a configured window count or continuously, with abort and irq-timeout recovery. Sits between the CPU-side control registers and the manager instance.

Parameters:
WINDOW_WIDTH, 32, width of cfg_window_cycles and the window counter
REPEAT_WIDTH, 16, width of cfg_repeat and windows_done
CLEAR_CYCLES, 4, cycles analyzer_clear is held high before each window (>=1)
START_PULSE_CYCLES, 2, analyzer_start high time (>=1)
GAP_CYCLES, 16, idle cycles between consecutive windows (0 allowed)
IRQ_TIMEOUT_CYCLES, 1024, max wait for each irq edge before error

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
cmd_run  in  1  start sequence (level sampled in IDLE)
cmd_abort  in  1  terminate sequence cleanly
cfg_window_cycles  in  WINDOW_WIDTH  measurement window length in clocks
cfg_repeat  in  REPEAT_WIDTH  windows to run; 0 = continuous
analyzer_irq  in  1  manager irq (write_completed)
analyzer_clear  out  1  to manager clear
analyzer_start  out  1  to manager start
analyzer_stop  out  1  to manager stop
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse: all windows completed
aborted  out  1  one-cycle pulse: abort completed
timeout_err  out  1  sticky irq-timeout flag
windows_done  out  REPEAT_WIDTH  completed windows this run

Behaviour:
- Reset (async, aresetn=0): state IDLE; all outputs 0, windows_done=0, counters 0. Reset mid-sequence drops stop/start/clear immediately.
- States: IDLE, CLEAR, ARM, MEASURE, STOP_WAIT, RELEASE, GAP, ABORT_WAIT.
- IDLE: cmd_run=1 and cmd_abort=0 -> latch cfg_window_cycles (0 treated as 1) and cfg_repeat, clear windows_done and timeout_err, go CLEAR next cycle. cmd_run with cmd_abort simultaneously: ignored.
- CLEAR: analyzer_clear=1 exactly CLEAR_CYCLES cycles -> ARM.
- ARM: analyzer_start=1 exactly START_PULSE_CYCLES cycles -> MEASURE.
- MEASURE: all drive pins 0; stay exactly latched window cycles -> STOP_WAIT.
- STOP_WAIT: analyzer_stop=1; irq=1 -> RELEASE. No irq within IRQ_TIMEOUT_CYCLES -> set timeout_err, stop=0, IDLE (no done).
- RELEASE: stop=0; wait irq=0; on irq low increment windows_done (saturate at all-ones) then: repeat!=0 and windows_done+1==repeat -> pulse done, IDLE; else GAP (or CLEAR directly if GAP_CYCLES=0). irq stuck high beyond IRQ_TIMEOUT_CYCLES -> timeout_err, IDLE.
- GAP: GAP_CYCLES cycles all pins 0 -> CLEAR.
- cmd_abort in CLEAR/ARM/MEASURE/GAP: next cycle ABORT_WAIT (start/clear drop to 0). ABORT_WAIT behaves as STOP_WAIT then RELEASE but ends with aborted pulse and no windows_done increment; timeout there sets timeout_err and still pulses aborted. cmd_abort in STOP_WAIT/RELEASE: finish current handshake, then aborted instead of continuing/done (window counted).
- analyzer_start and analyzer_stop never high in the same cycle; start only asserted with stop low.
- cfg changes while busy have no effect until next run.
- All outputs registered; done/aborted exactly one cycle.

Optional Feature:
WINDOW_TIMESTAMP_EN: adds free-running 32-bit cycle counter (reset 0, wraps) and output last_window_start[31:0], loaded with counter value on the cycle ARM is entered; reset 0. Without macro: no counter, no port.

Test Plan:
- cfg_window_cycles=100, cfg_repeat=1, irq model asserts 8 cycles after stop, drops 1 cycle after stop low -> clear 4 cyc, start 2 cyc, 100 cyc measure, stop until irq, done pulse, windows_done=1.
- cfg_repeat=3, GAP_CYCLES=16 -> three windows, 16 idle cycles between each, done after third, windows_done=3.
- cfg_repeat=0, abort during 2nd MEASURE -> stop asserted next cycle, aborted pulse after irq handshake, windows_done=1, no done.
- irq never asserted -> timeout_err=1 after 1024 cycles of stop, stop drops, busy=0; next cmd_run clears timeout_err.
- cfg_window_cycles=0 -> MEASURE lasts 1 cycle; cmd_run+cmd_abort together in IDLE -> stays IDLE, busy=0.
- Assert aresetn=0 during STOP_WAIT -> stop/start/clear/busy 0 immediately, windows_done=0.

Source files
------------

// File: rtl/measurement_window_scheduler.sv
// measurement_window_scheduler
// Sequences repeated measurement windows of a frequency_analyzer_manager:
// clear -> start -> measure -> stop/irq handshake -> gap, for a configured
// window count or continuously, with abort and irq-timeout recovery.
//
// Handshake with the manager: analyzer_stop is raised and held until
// analyzer_irq is seen high (register dump complete), then stop is dropped
// and the scheduler waits for irq to return low before the window is
// considered finished. Each wait is bounded by IRQ_TIMEOUT_CYCLES.
//
// Optional build macro WINDOW_TIMESTAMP_EN adds a free-running 32-bit cycle
// counter and the last_window_start output (counter value when ARM entered).
module measurement_window_scheduler #(
  parameter int WINDOW_WIDTH       = 32,
  parameter int REPEAT_WIDTH       = 16,
  parameter int CLEAR_CYCLES       = 4,
  parameter int START_PULSE_CYCLES = 2,
  parameter int GAP_CYCLES         = 16,
  parameter int IRQ_TIMEOUT_CYCLES = 1024
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  input  logic                    cmd_run,
  input  logic                    cmd_abort,
  input  logic [WINDOW_WIDTH-1:0] cfg_window_cycles,
  input  logic [REPEAT_WIDTH-1:0] cfg_repeat,
  input  logic                    analyzer_irq,
  output logic                    analyzer_clear,
  output logic                    analyzer_start,
  output logic                    analyzer_stop,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    timeout_err,
  output logic [REPEAT_WIDTH-1:0] windows_done,
`ifdef WINDOW_TIMESTAMP_EN
  output logic [31:0]             last_window_start,
`endif
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CLEAR      = 3'd1,
    S_ARM        = 3'd2,
    S_MEASURE    = 3'd3,
    S_STOP_WAIT  = 3'd4,
    S_RELEASE    = 3'd5,
    S_GAP        = 3'd6,
    S_ABORT_WAIT = 3'd7
  } state_t;

  // One shared phase counter; wide enough for the window length and timeouts.
  localparam int CNT_W      = (WINDOW_WIDTH > 32) ? WINDOW_WIDTH : 32;
  localparam int CLEAR_LAST = CLEAR_CYCLES - 1;
  localparam int START_LAST = START_PULSE_CYCLES - 1;
  localparam int GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int TO_LAST    = IRQ_TIMEOUT_CYCLES - 1;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [WINDOW_WIDTH-1:0] window_last, window_last_n;
  logic [REPEAT_WIDTH-1:0] repeat_q, repeat_n;
  logic [REPEAT_WIDTH-1:0] windows_done_n;
  logic                    abort_req, abort_req_n;   // abort seen during the stop/irq handshake
  logic                    flush_q, flush_n;         // handshake belongs to an aborted window
  logic                    timeout_err_n;
  logic                    done_n, aborted_n;
  logic                    last_window;

  assign state_dbg = state;

  // Window that is finishing now completes the configured count.
  assign last_window = (repeat_q != '0) &&
                       (({1'b0, windows_done} + (REPEAT_WIDTH+1)'(1)) == {1'b0, repeat_q});

  // Next-state, counter and status computation.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    window_last_n  = window_last;
    repeat_n       = repeat_q;
    abort_req_n    = abort_req;
    flush_n        = flush_q;
    windows_done_n = windows_done;
    timeout_err_n  = timeout_err;
    done_n         = 1'b0;
    aborted_n      = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_run && !cmd_abort) begin
          window_last_n  = (cfg_window_cycles == '0) ? '0
                           : cfg_window_cycles - WINDOW_WIDTH'(1);
          repeat_n       = cfg_repeat;
          windows_done_n = '0;
          timeout_err_n  = 1'b0;
          abort_req_n    = 1'b0;
          flush_n        = 1'b0;
          cnt_n          = '0;
          state_n        = S_CLEAR;
        end
      end

      S_CLEAR: begin
        if (cmd_abort) begin
          cnt_n   = '0;
          state_n = S_ABORT_WAIT;
        end else if (cnt == CNT_W'(CLEAR_LAST)) begin
          cnt_n   = '0;
          state_n = S_ARM;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_ARM: begin
        if (cmd_abort) begin
          cnt_n   = '0;
          state_n = S_ABORT_WAIT;
        end else if (cnt == CNT_W'(START_LAST)) begin
          cnt_n   = '0;
          state_n = S_MEASURE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_MEASURE: begin
        if (cmd_abort) begin
          cnt_n   = '0;
          state_n = S_ABORT_WAIT;
        end else if (cnt == CNT_W'(window_last)) begin
          cnt_n   = '0;
          state_n = S_STOP_WAIT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_STOP_WAIT: begin
        if (cmd_abort) abort_req_n = 1'b1;
        if (analyzer_irq) begin
          cnt_n   = '0;
          state_n = S_RELEASE;
        end else if (cnt == CNT_W'(TO_LAST)) begin
          cnt_n         = '0;
          timeout_err_n = 1'b1;
          aborted_n     = abort_req || cmd_abort;
          state_n       = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_ABORT_WAIT: begin
        if (analyzer_irq) begin
          cnt_n   = '0;
          flush_n = 1'b1;
          state_n = S_RELEASE;
        end else if (cnt == CNT_W'(TO_LAST)) begin
          cnt_n         = '0;
          timeout_err_n = 1'b1;
          aborted_n     = 1'b1;
          state_n       = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        if (cmd_abort) abort_req_n = 1'b1;
        if (!analyzer_irq) begin
          cnt_n = '0;
          if (flush_q) begin
            aborted_n = 1'b1;
            state_n   = S_IDLE;
          end else begin
            if (windows_done != '1) windows_done_n = windows_done + REPEAT_WIDTH'(1);
            if (abort_req || cmd_abort) begin
              aborted_n = 1'b1;
              state_n   = S_IDLE;
            end else if (last_window) begin
              done_n  = 1'b1;
              state_n = S_IDLE;
            end else if (GAP_CYCLES == 0) begin
              state_n = S_CLEAR;
            end else begin
              state_n = S_GAP;
            end
          end
        end else if (cnt == CNT_W'(TO_LAST)) begin
          cnt_n         = '0;
          timeout_err_n = 1'b1;
          aborted_n     = flush_q || abort_req || cmd_abort;
          state_n       = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cmd_abort) begin
          cnt_n   = '0;
          state_n = S_ABORT_WAIT;
        end else if (cnt == CNT_W'(GAP_LAST)) begin
          cnt_n   = '0;
          state_n = S_CLEAR;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) state <= S_IDLE;
    else                  state <= state_n;
  end

  // Datapath registers: phase counter, latched configuration, run status.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      cnt          <= '0;
      window_last  <= '0;
      repeat_q     <= '0;
      abort_req    <= 1'b0;
      flush_q      <= 1'b0;
      windows_done <= '0;
      timeout_err  <= 1'b0;
    end else begin
      cnt          <= cnt_n;
      window_last  <= window_last_n;
      repeat_q     <= repeat_n;
      abort_req    <= abort_req_n;
      flush_q      <= flush_n;
      windows_done <= windows_done_n;
      timeout_err  <= timeout_err_n;
    end
  end

  // Registered pin drives decoded from the next state, so they line up with state.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      analyzer_clear <= 1'b0;
      analyzer_start <= 1'b0;
      analyzer_stop  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
    end else begin
      analyzer_clear <= (state_n == S_CLEAR);
      analyzer_start <= (state_n == S_ARM);
      analyzer_stop  <= (state_n == S_STOP_WAIT) || (state_n == S_ABORT_WAIT);
      busy           <= (state_n != S_IDLE);
      done           <= done_n;
      aborted        <= aborted_n;
    end
  end

`ifdef WINDOW_TIMESTAMP_EN
  logic [31:0] cycle_count;

  // Free-running cycle counter; sampled when a window is armed.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      cycle_count       <= '0;
      last_window_start <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (state_n == S_ARM && state != S_ARM) last_window_start <= cycle_count;
    end
  end
`endif

endmodule

// File: tb/tb_measurement_window_scheduler.sv
// Bench for measurement_window_scheduler: randomized runs against a
// phase-level model. The model predicts the run-length trace of the
// {clear,start,stop} pins while busy, plus end-of-run status.
module tb_measurement_window_scheduler;
  localparam int WW      = 32;
  localparam int RW      = 16;
  localparam int CLEAR_C = 4;
  localparam int START_C = 2;
  localparam int GAP_C   = 16;
  localparam int TO_C    = 1024;

  // Clock and reset.
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_run = 1'b0, cmd_abort = 1'b0;
  logic [WW-1:0] cfg_window_cycles = '0;
  logic [RW-1:0] cfg_repeat = '0;
  logic          analyzer_irq = 1'b0;
  logic          analyzer_clear, analyzer_start, analyzer_stop;
  logic          busy, done, aborted, timeout_err;
  logic [RW-1:0] windows_done;
  logic [2:0]    state_dbg;

  measurement_window_scheduler #(
    .WINDOW_WIDTH(WW), .REPEAT_WIDTH(RW), .CLEAR_CYCLES(CLEAR_C),
    .START_PULSE_CYCLES(START_C), .GAP_CYCLES(GAP_C), .IRQ_TIMEOUT_CYCLES(TO_C)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .cmd_run(cmd_run), .cmd_abort(cmd_abort),
    .cfg_window_cycles(cfg_window_cycles), .cfg_repeat(cfg_repeat),
    .analyzer_irq(analyzer_irq),
    .analyzer_clear(analyzer_clear), .analyzer_start(analyzer_start),
    .analyzer_stop(analyzer_stop), .busy(busy), .done(done), .aborted(aborted),
    .timeout_err(timeout_err), .windows_done(windows_done), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int dly_q[$];

  // Manager irq model: irq rises after the per-window delay of stop cycles,
  // and falls on the second cycle after stop is seen low.
  bit irq_on = 1'b1;
  int stop_run = 0, low_run = 0, cur_delay = 8;
  always @(posedge clk) begin
    #1;
    if (analyzer_stop) begin
      if (stop_run == 0) cur_delay = (dly_q.size() > 0) ? dly_q.pop_front() : 8;
      stop_run++;
      low_run = 0;
    end else begin
      stop_run = 0;
      low_run++;
    end
    if (!irq_on) analyzer_irq = 1'b0;
    else if (analyzer_stop) analyzer_irq = (stop_run >= cur_delay);
    else if (low_run >= 2) analyzer_irq = 1'b0;
  end

  // Monitor: run-length trace of pin pattern while busy, pulse bookkeeping.
  logic [2:0] cur_pat, pat;
  int seg_len = 0;
  bit in_seg = 0, prev_busy = 0;
  int done_cnt = 0, aborted_cnt = 0, bad_pulse = 0, overlap = 0;
  always @(negedge clk) begin
    pat = {analyzer_clear, analyzer_start, analyzer_stop};
    if (busy) begin
      if (in_seg && pat == cur_pat) seg_len++;
      else begin
        if (in_seg) obs_q.push_back({cur_pat, 29'(seg_len)});
        cur_pat = pat;
        seg_len = 1;
        in_seg  = 1;
      end
    end else if (in_seg) begin
      obs_q.push_back({cur_pat, 29'(seg_len)});
      in_seg = 0;
    end
    if (analyzer_start && analyzer_stop) overlap++;
    if (done) begin
      done_cnt++;
      if (!(prev_busy && !busy)) bad_pulse++;
    end
    if (aborted) begin
      aborted_cnt++;
      if (!(prev_busy && !busy)) bad_pulse++;
    end
    prev_busy = busy;
  end

  // Scoreboard helpers.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seg(input logic [2:0] p, input int len);
    exp_q.push_back({p, 29'(len)});
  endtask

  // One window: clear, start pulse, measure, stop until irq, release (+gap).
  task automatic model_window(input int w, input int d, input bit last_one);
    push_seg(3'b100, CLEAR_C);
    push_seg(3'b010, START_C);
    push_seg(3'b000, (w == 0) ? 1 : w);
    push_seg(3'b001, d);
    push_seg(3'b000, last_one ? 2 : 2 + GAP_C);
    dly_q.push_back(d);
  endtask

  task automatic start_run(input int w, input int r);
    cfg_window_cycles = WW'(w);
    cfg_repeat        = RW'(r);
    cmd_run           = 1'b1;
    step();
    cmd_run = 1'b0;
    // Configuration changes during a run must be ignored.
    cfg_window_cycles = $urandom;
    cfg_repeat        = RW'($urandom_range(0, 65535));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check({tag, "_finish"}, busy, 1'b0);
    step();
    step();
  endtask

  task automatic compare_trace(input string tag);
    check({tag, "_nseg"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check($sformatf("%s_seg%0d", tag, i), obs_q[i], exp_q[i]);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic clean_run(input string tag, input int w, input int r);
    int d0, a0;
    d0 = done_cnt;
    a0 = aborted_cnt;
    dly_q.delete();
    for (int i = 1; i <= r; i++) model_window(w, $urandom_range(1, 12), i == r);
    start_run(w, r);
    wait_idle(tag, 4000);
    compare_trace(tag);
    check({tag, "_windows_done"}, windows_done, RW'(r));
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_aborted"}, aborted_cnt - a0, 0);
    check({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  int w, k, d1, d2, n, falls, d0, a0;
  bit prev_start;

  initial begin
    // Reset state.
    #1 rst_n = 1'b0;
    repeat (3) step();
    check("reset_outputs",
          {analyzer_clear, analyzer_start, analyzer_stop, busy, done, aborted, timeout_err},
          7'b0);
    check("reset_windows_done", windows_done, '0);
    rst_n = 1'b1;
    repeat (2) step();

    // Single 100-cycle window, irq 8 cycles after stop.
    dly_q.delete();
    model_window(100, 8, 1'b1);
    d0 = done_cnt;
    start_run(100, 1);
    wait_idle("single", 2000);
    compare_trace("single");
    check("single_windows_done", windows_done, RW'(1));
    check("single_done", done_cnt - d0, 1);

    // Three windows with gaps.
    clean_run("three", $urandom_range(5, 40), 3);

    // Randomized runs, including zero window length.
    clean_run("wzero", 0, 2);
    for (int t = 0; t < 4; t++)
      clean_run($sformatf("rand%0d", t), $urandom_range(0, 25), $urandom_range(1, 3));

    // Continuous mode, abort during the second MEASURE.
    w  = $urandom_range(10, 30);
    d1 = $urandom_range(1, 12);
    d2 = $urandom_range(1, 12);
    k  = $urandom_range(0, w - 2);
    dly_q.delete();
    model_window(w, d1, 1'b0);
    push_seg(3'b100, CLEAR_C);
    push_seg(3'b010, START_C);
    push_seg(3'b000, k + 1);
    push_seg(3'b001, d2);
    push_seg(3'b000, 2);
    dly_q.push_back(d2);
    d0 = done_cnt;
    a0 = aborted_cnt;
    start_run(w, 0);
    falls = 0;
    n = 0;
    prev_start = 1'b0;
    while (falls < 2 && n < 2000) begin
      if (prev_start && !analyzer_start) falls++;
      prev_start = analyzer_start;
      if (falls < 2) step();
      n++;
    end
    check("abort_reach_measure2", falls, 2);
    repeat (k) step();
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    wait_idle("abort", 2000);
    compare_trace("abort");
    check("abort_windows_done", windows_done, RW'(1));
    check("abort_aborted", aborted_cnt - a0, 1);
    check("abort_done", done_cnt - d0, 0);

    // irq never arrives: timeout after the full stop wait.
    irq_on = 1'b0;
    dly_q.delete();
    push_seg(3'b100, CLEAR_C);
    push_seg(3'b010, START_C);
    push_seg(3'b000, 10);
    push_seg(3'b001, TO_C);
    d0 = done_cnt;
    start_run(10, 1);
    wait_idle("timeout", 3000);
    compare_trace("timeout");
    check("timeout_err_set", timeout_err, 1'b1);
    check("timeout_done", done_cnt - d0, 0);
    check("timeout_windows_done", windows_done, '0);
    irq_on = 1'b1;
    repeat (3) step();

    // Next run clears the sticky timeout flag.
    dly_q.delete();
    model_window(5, 3, 1'b1);
    start_run(5, 1);
    check("timeout_cleared", timeout_err, 1'b0);
    wait_idle("after_to", 2000);
    compare_trace("after_to");

    // cmd_run together with cmd_abort in IDLE is ignored.
    cfg_window_cycles = 32'd7;
    cfg_repeat        = 16'd1;
    cmd_run           = 1'b1;
    cmd_abort         = 1'b1;
    repeat (3) step();
    check("run_abort_busy", busy, 1'b0);
    cmd_run   = 1'b0;
    cmd_abort = 1'b0;
    step();
    check("run_abort_clear", analyzer_clear, 1'b0);

    // Reset in STOP_WAIT of the second window drops everything at once.
    dly_q.delete();
    dly_q.push_back(4);
    dly_q.push_back(50);
    start_run(20, 2);
    falls = 0;
    n = 0;
    prev_start = 1'b0;
    while (falls < 2 && n < 2000) begin
      if (!prev_start && analyzer_stop) falls++;
      prev_start = analyzer_stop;
      if (falls < 2) step();
      n++;
    end
    check("reset_reach_stop2", falls, 2);
    check("reset_pre_windows_done", windows_done, RW'(1));
    step();
    rst_n = 1'b0;
    #1;
    check("reset_mid_pins", {analyzer_clear, analyzer_start, analyzer_stop, busy}, 4'b0);
    check("reset_mid_windows_done", windows_done, '0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    check("reset_after_busy", busy, 1'b0);
    exp_q.delete();
    obs_q.delete();

    // Global pulse and exclusivity properties.
    check("pulse_shape", bad_pulse, 0);
    check("start_stop_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
